if_fetch: RTL and testbench

Instruction-fetch stage sitting between the PC register and the IF_ID pipeline register. It consumes the current PC and reads the 32-bit instruction word from the byte-wide memory controller port as four little-endian byte transfers. It holds the pipeline via a stall request while a fetch is outstanding, and discards in-flight work on a jump. An optional direct-mapped instruction cache short-circuits repeat fetches.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch_icache.sv | 62 ++++++
 rtl/if_fetch.sv | 100 ++++++++++
 tb/tb_if_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared encodings and widths for the instruction-fetch stage and its
// optional instruction cache (enabled with ICACHE_EN).
package if_fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [ADDR_W-1:0] ZERO32 = '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int ICACHE_TAG_MSB = 17;

  function automatic int icache_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int icache_tag_w(input int entries);
    return ICACHE_TAG_MSB - 1 - $clog2(entries);
  endfunction
endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache. Storage exists only when
// ICACHE_EN is defined; otherwise the block always reports a miss.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data
);
`ifdef ICACHE_EN
  localparam int IDX_W = icache_idx_w(ENTRIES);
  localparam int TAG_W = icache_tag_w(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [INST_W-1:0]  data_mem [ENTRIES];
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [TAG_W-1:0]   wr_tag;
  logic               unused_addr_bits;

  assign rd_idx = rd_addr[IDX_W+1:2];
  assign rd_tag = rd_addr[ICACHE_TAG_MSB:IDX_W+2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_tag = wr_addr[ICACHE_TAG_MSB:IDX_W+2];
  assign unused_addr_bits = ^{rd_addr[ADDR_W-1:ICACHE_TAG_MSB+1], rd_addr[1:0],
                              wr_addr[ADDR_W-1:ICACHE_TAG_MSB+1], wr_addr[1:0]};

  assign rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits gate every read.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end
`else
  logic unused_cache_inputs;

  assign rd_hit  = 1'b0;
  assign rd_data = ZERO32;
  assign unused_cache_inputs = ^{clk_in, rst_in, rd_addr, wr_en, wr_addr, wr_data, ENTRIES > 0};
`endif
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit word from four little-endian byte reads,
// stalls the PC while outstanding, flushes on jump. Optional cache: ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_ENTRIES = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              jump_in,
  input  logic              stall_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [BYTE_W-1:0] mem_data_in,
  input  logic              mem_valid_in,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  output logic              inst_valid_out,
  output logic              stall_req_out
);
  logic [1:0]        state_q;
  logic [1:0]        cnt_q;
  logic [INST_W-1:0] buf_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pc_word;
  logic              hit;
  logic [INST_W-1:0] hit_data;
  logic              fill_en;
  logic              unused_pc_bits;

  assign pc_word        = {pc_in[ADDR_W-1:2], 2'b00};
  assign unused_pc_bits = ^pc_in[1:0];

  // Last byte of a miss lands straight in the cache alongside the first three.
  assign fill_en = rdy_in && !jump_in && (state_q == ST_FETCH) &&
                   mem_valid_in && (cnt_q == 2'd3);

  if_fetch_icache #(
    .ENTRIES (ICACHE_ENTRIES)
  ) u_icache (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_addr (pc_word),
    .rd_hit  (hit),
    .rd_data (hit_data),
    .wr_en   (fill_en),
    .wr_addr (fetch_pc_q),
    .wr_data ({mem_data_in, buf_q[23:0]})
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      buf_q      <= ZERO32;
      fetch_pc_q <= ZERO32;
    end else if (rdy_in) begin
      if (jump_in) begin
        state_q <= ST_IDLE;
        cnt_q   <= 2'd0;
        buf_q   <= ZERO32;
      end else begin
        case (state_q)
          ST_IDLE: begin
            fetch_pc_q <= pc_word;
            cnt_q      <= 2'd0;
            if (hit) begin
              buf_q   <= hit_data;
              state_q <= ST_DONE;
            end else begin
              buf_q   <= ZERO32;
              state_q <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (mem_valid_in) begin
              buf_q[{cnt_q, 3'b000} +: BYTE_W] <= mem_data_in;
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (!stall_in) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Request drops in the jump cycle itself so the controller aborts at once.
  assign mem_req_out    = (state_q == ST_FETCH) && !jump_in;
  assign mem_addr_out   = fetch_pc_q + {{(ADDR_W-2){1'b0}}, cnt_q};
  assign inst_out       = buf_q;
  assign inst_pc_out    = fetch_pc_q;
  assign inst_valid_out = (state_q == ST_DONE);
  assign stall_req_out  = rst_in && (((state_q == ST_IDLE) && !hit) || (state_q == ST_FETCH));
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch against a word-level fetch model with a
// byte memory array and (when ICACHE_EN is defined) a direct-mapped cache model.
module tb_if_fetch;
  localparam int N = 64;
`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_in;
  logic        jump_in;
  logic        stall_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  logic        mem_valid_in;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_valid_out;
  logic        stall_req_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem    [4096];
  bit          mv     [N];
  logic [31:0] maddr  [N];
  logic [31:0] mwordc [N];

  if_fetch #(.ICACHE_ENTRIES(N)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .pc_in          (pc_in),
    .jump_in        (jump_in),
    .stall_in       (stall_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_in    (mem_data_in),
    .mem_valid_in   (mem_valid_in),
    .inst_out       (inst_out),
    .inst_pc_out    (inst_pc_out),
    .inst_valid_out (inst_valid_out),
    .stall_req_out  (stall_req_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i;
    i = line_of(a);
    return CACHE_ON && mv[i] && (maddr[i][17:2] == a[17:2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   mem_req_out,    32'd0);
    check({tag, "_addr"},  mem_addr_out,   32'd0);
    check({tag, "_inst"},  inst_out,       32'd0);
    check({tag, "_ipc"},   inst_pc_out,    32'd0);
    check({tag, "_vld"},   inst_valid_out, 32'd0);
    check({tag, "_stall"}, stall_req_out,  32'd0);
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_fetch(input logic [31:0] pc, input int max_gap, input int hold_at,
                          input int hold_n, input bit hold_frz, input int stall_n,
                          input bit jump_done);
    logic [31:0] wpc, exp_word;
    bit exp_hit, saw_req;
    int nb, cyc, extra, held, stall_seen;
    wpc      = {pc[31:2], 2'b00};
    exp_hit  = model_hit(wpc);
    exp_word = exp_hit ? mwordc[line_of(wpc)] : mem_word(wpc);
    pc_in = pc;
    mem_valid_in = 1'b0;
    #1;
    check("idle_stall_req", stall_req_out, {31'd0, !exp_hit});
    check("idle_req", mem_req_out, 32'd0);
    stall_seen = stall_req_out; cyc = 1; nb = 0; extra = 0; held = 0; saw_req = 1'b0;
    while (cyc < 80) begin
      @(negedge clk_in);
      cyc++;
      mem_valid_in = 1'b0;
      rdy_in = 1'b1;
      if (inst_valid_out) break;
      stall_seen += stall_req_out;
      if (mem_req_out) begin
        saw_req = 1'b1;
        check("fetch_addr", mem_addr_out, wpc + nb);
        if (nb == hold_at && held < hold_n) begin
          held++; extra++;
          if (hold_frz) begin
            rdy_in = 1'b0;
            mem_valid_in = 1'b1;
            mem_data_in = 8'($urandom);
          end
        end else if ($urandom_range(0, max_gap) == 0) begin
          mem_valid_in = 1'b1;
          mem_data_in = mb(wpc + nb);
          nb++;
        end else begin
          extra++;
        end
      end
    end
    check("inst_valid", inst_valid_out, 32'd1);
    check("inst_word", inst_out, exp_word);
    check("inst_pc", inst_pc_out, wpc);
    check("latency", cyc, exp_hit ? 2 : 6 + extra);
    check("stall_cycles", stall_seen, exp_hit ? 0 : 5 + extra);
    check("mem_req_seen", saw_req, {31'd0, !exp_hit});
    if (!exp_hit && CACHE_ON) begin
      mv[line_of(wpc)] = 1'b1;
      maddr[line_of(wpc)] = wpc;
      mwordc[line_of(wpc)] = exp_word;
    end
    if (jump_done) begin
      stall_in = 1'b1;
      jump_in = 1'b1;
      @(negedge clk_in);
      check("jump_beats_stall", inst_valid_out, 32'd0);
      jump_in = 1'b0;
      stall_in = 1'b0;
    end else begin
      for (int s = 0; s < stall_n; s++) begin
        stall_in = 1'b1;
        @(negedge clk_in);
        check("stall_vld", inst_valid_out, 32'd1);
        check("stall_inst", inst_out, exp_word);
        check("stall_pc", inst_pc_out, wpc);
      end
      stall_in = 1'b0;
      @(negedge clk_in);
      check("vld_drop", inst_valid_out, 32'd0);
    end
  endtask

  // Delivers two bytes of a miss, then acts while cnt==2.
  task automatic two_bytes(input logic [31:0] pc);
    int nb;
    nb = 0;
    pc_in = pc;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      @(negedge clk_in);
      mem_valid_in = 1'b0;
      if (mem_req_out) begin
        mem_valid_in = 1'b1;
        mem_data_in = mb(pc + nb);
        nb++;
      end
    end
    @(negedge clk_in);
    mem_valid_in = 1'b0;
    check("cnt2_addr", mem_addr_out, pc + 32'd2);
  endtask

  initial begin
    logic [31:0] pc;
    rst_in = 1'b0; rdy_in = 1'b1; pc_in = '0; jump_in = 1'b0; stall_in = 1'b0;
    mem_valid_in = 1'b0; mem_data_in = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    model_clear();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    rst_in = 1'b1;

    do_fetch(32'h0, 0, -1, 0, 1'b0, 0, 1'b0);
    check("tp_word", mem_word(32'h0), 32'h0010_0513);
    do_fetch(32'h8, 0, 2, 2, 1'b0, 0, 1'b0);

    two_bytes(32'h10);
    jump_in = 1'b1; mem_valid_in = 1'b1; mem_data_in = 8'hEE;
    #1 check("jump_req_drop", mem_req_out, 32'd0);
    @(negedge clk_in);
    jump_in = 1'b0; mem_valid_in = 1'b0;
    check("jump_no_vld", inst_valid_out, 32'd0);
    check("jump_idle_req", mem_req_out, 32'd0);
    do_fetch(32'h100, 0, -1, 0, 1'b0, 0, 1'b0);

    do_fetch(32'h20, 1, -1, 0, 1'b0, 3, 1'b0);
    do_fetch(32'h30, 0, 1, 3, 1'b1, 0, 1'b0);

    do_fetch(32'h40, 0, -1, 0, 1'b0, 0, 1'b0);
    do_fetch(32'h40, 0, -1, 0, 1'b0, 0, 1'b0);
    do_fetch(32'h40 + 4 * N, 0, -1, 0, 1'b0, 0, 1'b0);
    do_fetch(32'h40, 0, -1, 0, 1'b0, 1, 1'b0);
    do_fetch(32'h50, 1, -1, 0, 1'b0, 0, 1'b1);
    do_fetch(32'hFFFF_FFFE, 0, -1, 0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      pc = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) pc = pc | 32'h0004_0000;
      pc = pc | 32'($urandom_range(0, 3));
      do_fetch(pc, int'($urandom_range(0, 2)), -1, 0, 1'b0, int'($urandom_range(0, 2)),
               $urandom_range(0, 5) == 0);
    end

    two_bytes(32'h60);
    check("pre_rst_req", mem_req_out, 32'd1);
    rst_in = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk_in);
    rst_in = 1'b1;
    model_clear();
    do_fetch(32'h40, 0, -1, 0, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
